// File: rtl/if_fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage: next-PC select and run-state encodings,
// default halt/nop words.
package if_fetch_unit_pkg;

  typedef enum logic [1:0] {
    IF_IDLE    = 2'd0,
    IF_RUN     = 2'd1,
    IF_HALTED  = 2'd2
  } if_state_e;

  typedef enum logic [1:0] {
    PC_SEL_SEQ    = 2'b00,
    PC_SEL_BRANCH = 2'b01,
    PC_SEL_JUMP   = 2'b10
  } pc_sel_e;

  localparam logic [31:0] IF_HALT_WORD_DEF = 32'hFC00_0000;
  localparam logic [31:0] IF_NOP_WORD_DEF  = 32'h0000_0000;

  // Select code 11 falls through to sequential.
  function automatic logic is_redirect(input logic [1:0] sel);
    return (sel == PC_SEL_BRANCH) || (sel == PC_SEL_JUMP);
  endfunction

endpackage

// File: rtl/if_instr_rom.sv
// Instruction store: one synchronous write port for program load, one asynchronous read port for fetch.
module if_instr_rom #(
  parameter int DATA_W    = 32,
  parameter int MEM_DEPTH = 256,
  localparam int IDX_W    = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [IDX_W-1:0]  rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_q [MEM_DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[wr_addr] <= wr_data;
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC register, seq/branch/jump next-PC select, halt detection, run-control FSM.
// Optional single-step fetch is enabled by defining IF_STEP_EN.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int MEM_DEPTH = 256,
  parameter int PC_INC    = 1,
  parameter logic [DATA_W-1:0] HALT_WORD = DATA_W'(IF_HALT_WORD_DEF),
  parameter logic [DATA_W-1:0] NOP_WORD  = DATA_W'(IF_NOP_WORD_DEF),
  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic              i_enable,
  input  logic              i_stall,
  input  logic [1:0]        i_pc_sel,
  input  logic [ADDR_W-1:0] i_branch_addr,
  input  logic [ADDR_W-1:0] i_jump_addr,
  input  logic              i_wr_en,
  input  logic [IDX_W-1:0]  i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_step,
  output logic [ADDR_W-1:0] o_pc,
  output logic [DATA_W-1:0] o_instr,
  output logic [ADDR_W-1:0] o_instr_pc_inc,
  output logic              o_valid,
  output logic              o_halt,
  output logic [1:0]        o_state
);

  if_state_e         state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, inc_q, inc_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic              valid_q, valid_d, halt_q, halt_d;

  logic [DATA_W-1:0] rom_data;
  logic [ADDR_W-1:0] pc_plus;
  logic              rom_we, step_ok;

`ifdef IF_STEP_EN
  assign step_ok = i_step;
`else
  logic unused_step;
  assign unused_step = i_step;
  assign step_ok     = 1'b1;
`endif

  assign pc_plus = pc_q + ADDR_W'(PC_INC);
  assign rom_we  = i_wr_en & i_enable & (state_q == IF_IDLE);

  if_instr_rom #(
    .DATA_W    (DATA_W),
    .MEM_DEPTH (MEM_DEPTH)
  ) u_rom (
    .clk     (i_clk),
    .we      (rom_we),
    .wr_addr (i_wr_addr),
    .wr_data (i_wr_data),
    .rd_addr (IDX_W'(pc_q)),
    .rd_data (rom_data)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inc_d   = inc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    halt_d  = halt_q;
    if (i_enable) begin
      case (state_q)
        IF_IDLE: begin
          pc_d    = '0;
          instr_d = NOP_WORD;
          valid_d = 1'b0;
          if (i_start) state_d = IF_RUN;
        end
        IF_RUN: begin
          if (!i_stall) begin
            // A non-step cycle holds the slot but drops valid so ID does not re-issue it.
            if (!step_ok) begin
              valid_d = 1'b0;
            end else begin
              inc_d   = pc_plus;
              valid_d = 1'b1;
              if (is_redirect(i_pc_sel)) begin
                instr_d = NOP_WORD;
                valid_d = 1'b0;
                pc_d    = (i_pc_sel == PC_SEL_JUMP) ? i_jump_addr : i_branch_addr;
              end else if (rom_data == HALT_WORD) begin
                instr_d = HALT_WORD;
                halt_d  = 1'b1;
                state_d = IF_HALTED;
              end else begin
                instr_d = rom_data;
                pc_d    = pc_plus;
              end
            end
          end
        end
        IF_HALTED: begin
          instr_d = NOP_WORD;
          valid_d = 1'b0;
        end
        default: state_d = IF_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= IF_IDLE;
      pc_q    <= '0;
      inc_q   <= '0;
      instr_q <= NOP_WORD;
      valid_q <= 1'b0;
      halt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inc_q   <= inc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      halt_q  <= halt_d;
    end
  end

  assign o_pc           = pc_q;
  assign o_instr        = instr_q;
  assign o_instr_pc_inc = inc_q;
  assign o_valid        = valid_q;
  assign o_halt         = halt_q;
  assign o_state        = state_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed vector table, wrap sequence on a narrow instance, and a random
// run against a word-level reference model.
module tb_if_fetch_unit;

  localparam logic [31:0] HALT = 32'hFC00_0000;
  localparam logic [31:0] NOP  = 32'h0000_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, en, stall, step, wr_en;
  logic [1:0]  sel;
  logic [31:0] br, jmp, wr_data;
  logic [7:0]  wr_addr;

  logic [31:0] pc, instr, inc;
  logic        valid, halt;
  logic [1:0]  st;
  logic [3:0]  pc2, inc2;
  logic [31:0] instr2;
  logic        valid2, halt2;
  logic [1:0]  st2;

  int checks = 0;
  int errors = 0;

  if_fetch_unit dut (
    .i_clk(clk), .i_reset(rst), .i_start(start), .i_enable(en), .i_stall(stall),
    .i_pc_sel(sel), .i_branch_addr(br), .i_jump_addr(jmp), .i_wr_en(wr_en),
    .i_wr_addr(wr_addr), .i_wr_data(wr_data), .i_step(step),
    .o_pc(pc), .o_instr(instr), .o_instr_pc_inc(inc), .o_valid(valid),
    .o_halt(halt), .o_state(st)
  );

  if_fetch_unit #(.ADDR_W(4), .MEM_DEPTH(8)) dut_w (
    .i_clk(clk), .i_reset(rst), .i_start(start), .i_enable(en), .i_stall(stall),
    .i_pc_sel(sel), .i_branch_addr(br[3:0]), .i_jump_addr(jmp[3:0]), .i_wr_en(wr_en),
    .i_wr_addr(wr_addr[2:0]), .i_wr_data(wr_data), .i_step(step),
    .o_pc(pc2), .o_instr(instr2), .o_instr_pc_inc(inc2), .o_valid(valid2),
    .o_halt(halt2), .o_state(st2)
  );

  typedef struct {
    logic rst, start, en, stall;
    logic [1:0] sel;
    logic [31:0] tgt;
    logic wr;
    logic [7:0] wa;
    logic [31:0] wd;
    logic [31:0] e_pc, e_instr, e_inc;
    logic e_v, e_h;
    logic [1:0] e_st;
  } vec_t;
  vec_t vecs[$];

  task automatic add(input int r, s, e, stl, sl, input logic [31:0] tg, input int w, wa,
                     input logic [31:0] wd, ep, ei, einc, input int ev, eh, es);
    vec_t t;
    t.rst = (r != 0); t.start = (s != 0); t.en = (e != 0); t.stall = (stl != 0);
    t.sel = 2'(sl); t.tgt = tg; t.wr = (w != 0); t.wa = 8'(wa); t.wd = wd;
    t.e_pc = ep; t.e_instr = ei; t.e_inc = einc; t.e_v = (ev != 0); t.e_h = (eh != 0);
    t.e_st = 2'(es);
    vecs.push_back(t);
  endtask

  task automatic load(input int wa, input logic [31:0] wd);
    add(0, 0, 1, 0, 0, 0, 1, wa, wd, 0, NOP, 0, 0, 0, 0);
  endtask

  task automatic chk(input string nm, input logic [31:0] ap, ep, ai, ei, ainc, einc,
                     input logic av, ev, ah, eh, input logic [1:0] as_, es);
    checks++;
    if ({ap, ai, ainc, av, ah, as_} !== {ep, ei, einc, ev, eh, es}) begin
      errors++;
      $display("FAIL %s: got pc=%h instr=%h inc=%h v=%b h=%b st=%0d, want pc=%h instr=%h inc=%h v=%b h=%b st=%0d",
               nm, ap, ai, ainc, av, ah, as_, ep, ei, einc, ev, eh, es);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rst = 0; start = 0; en = 1; stall = 0; step = 1; wr_en = 0;
    sel = 0; br = 0; jmp = 0; wr_addr = 0; wr_data = 0;
  endtask

  // Word-level reference model of the fetch stage.
  logic [31:0] m_mem [256];
  logic [31:0] m_pc, m_instr, m_inc;
  logic        m_v, m_h;
  int          m_st;

  task automatic model_step();
    logic [31:0] w;
    logic step_ok;
    if (rst) begin
      m_pc = 0; m_instr = NOP; m_inc = 0; m_v = 0; m_h = 0; m_st = 0;
      return;
    end
    if (!en) return;
`ifdef IF_STEP_EN
    step_ok = step;
`else
    step_ok = 1'b1;
`endif
    if (m_st == 0) begin
      if (wr_en) m_mem[wr_addr] = wr_data;
      if (start) m_st = 1;
    end else if (m_st == 1) begin
      if (!stall) begin
        if (!step_ok) m_v = 0;
        else begin
          w = m_mem[m_pc % 256];
          m_inc = m_pc + 1;
          if (sel == 2'd1 || sel == 2'd2) begin
            m_instr = NOP; m_v = 0; m_pc = (sel == 2'd1) ? br : jmp;
          end else if (w == HALT) begin
            m_instr = HALT; m_v = 1; m_h = 1; m_st = 2;
          end else begin
            m_instr = w; m_v = 1; m_pc = m_pc + 1;
          end
        end
      end
    end else begin
      m_instr = NOP; m_v = 0;
    end
  endtask

  initial begin
    idle_inputs();

    // Directed table: load/run/halt, redirect, stall vs jump, enable hold, write lockout, reset.
    add(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, NOP, 0, 0, 0, 0);
    load(0, 32'h0049_6023); load(1, 1); load(2, 2); load(3, HALT);
    load(8'h10, 32'hCAFE_0010); load(8'h11, 32'hCAFE_0011);
    load(8'h12, 32'hAAAA_0012); load(8'h13, HALT);
    add(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, NOP, 0, 0, 0, 1);
    add(0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 32'h0049_6023, 1, 1, 0, 1);
    add(0, 0, 1, 0, 0, 0, 0, 0, 0, 2, 1, 2, 1, 0, 1);
    add(0, 0, 1, 0, 0, 0, 0, 0, 0, 3, 2, 3, 1, 0, 1);
    add(0, 0, 1, 0, 0, 0, 0, 0, 0, 3, HALT, 4, 1, 1, 2);
    add(0, 1, 1, 0, 0, 0, 0, 0, 0, 3, NOP, 4, 0, 1, 2);
    add(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, NOP, 0, 0, 0, 0);
    load(3, 3);
    add(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, NOP, 0, 0, 0, 0);
    add(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, NOP, 0, 0, 0, 1);
    add(0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 32'h0049_6023, 1, 1, 0, 1);
    add(0, 0, 1, 0, 0, 0, 0, 0, 0, 2, 1, 2, 1, 0, 1);
    add(0, 0, 1, 0, 1, 32'h10, 0, 0, 0, 32'h10, NOP, 3, 0, 0, 1);
    add(0, 0, 1, 0, 0, 0, 0, 0, 0, 32'h11, 32'hCAFE_0010, 32'h11, 1, 0, 1);
    add(0, 0, 1, 1, 2, 32'h40, 0, 0, 0, 32'h11, 32'hCAFE_0010, 32'h11, 1, 0, 1);
    add(0, 0, 0, 0, 2, 32'h40, 0, 0, 0, 32'h11, 32'hCAFE_0010, 32'h11, 1, 0, 1);
    add(0, 0, 1, 0, 0, 0, 1, 8'h12, 32'h1234_5678, 32'h12, 32'hCAFE_0011, 32'h12, 1, 0, 1);
    add(0, 0, 1, 0, 0, 0, 0, 0, 0, 32'h13, 32'hAAAA_0012, 32'h13, 1, 0, 1);
    add(0, 0, 1, 0, 1, 32'h11, 0, 0, 0, 32'h11, NOP, 32'h14, 0, 0, 1);
    add(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, NOP, 0, 0, 0, 0);
    add(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, NOP, 0, 0, 0, 1);
    add(0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 32'h0049_6023, 1, 1, 0, 1);

    foreach (vecs[i]) begin
      rst = vecs[i].rst; start = vecs[i].start; en = vecs[i].en; stall = vecs[i].stall;
      sel = vecs[i].sel; br = vecs[i].tgt; jmp = vecs[i].tgt;
      wr_en = vecs[i].wr; wr_addr = vecs[i].wa; wr_data = vecs[i].wd;
      tick();
      chk($sformatf("vec%0d", i), pc, vecs[i].e_pc, instr, vecs[i].e_instr, inc, vecs[i].e_inc,
          valid, vecs[i].e_v, halt, vecs[i].e_h, st, vecs[i].e_st);
    end

    // Wrap on the narrow instance: index wraps at 8, PC wraps at 16.
    idle_inputs();
    rst = 1; tick();
    chk("wrap_rst", {28'd0, pc2}, 0, instr2, NOP, {28'd0, inc2}, 0, valid2, 0, halt2, 0, st2, 0);
    rst = 0;
    for (int a = 0; a < 8; a++) begin
      wr_en = 1; wr_addr = 8'(a); wr_data = 32'h100 + 32'(a); tick();
    end
    wr_en = 0; start = 1; tick(); start = 0;
    for (int k = 0; k < 16; k++) begin
      tick();
      chk($sformatf("wrap%0d", k), {28'd0, pc2}, 32'((k + 1) % 16), instr2, 32'h100 + 32'(k % 8),
          {28'd0, inc2}, 32'((k + 1) % 16), valid2, 1, halt2, 0, st2, 1);
    end

`ifdef IF_STEP_EN
    begin
      int nv;
      nv = 0;
      idle_inputs();
      rst = 1; tick(); rst = 0;
      start = 1; step = 0; tick(); start = 0;
      for (int k = 0; k < 12; k++) begin
        step = (k == 2 || k == 5 || k == 9);
        tick();
        if (valid) nv++;
      end
      checks++;
      if (nv != 3 || pc != 32'd3) begin
        errors++;
        $display("FAIL step: got valid_cycles=%0d pc=%0d, want valid_cycles=3 pc=3", nv, pc);
      end
    end
`endif

    // Random run against the reference model; memory fully loaded first so every word is known.
    idle_inputs();
    rst = 1; model_step(); tick();
    chk("rnd_rst", pc, m_pc, instr, m_instr, inc, m_inc, valid, m_v, halt, m_h, st, 2'(m_st));
    rst = 0;
    for (int a = 0; a < 256; a++) begin
      wr_en = 1; wr_addr = 8'(a);
      wr_data = ($urandom_range(0, 15) == 0) ? HALT : $urandom;
      model_step(); tick();
      chk("rnd_load", pc, m_pc, instr, m_instr, inc, m_inc, valid, m_v, halt, m_h, st, 2'(m_st));
    end
    for (int k = 0; k < 3000; k++) begin
      int r;
      rst   = ($urandom_range(0, 59) == 0);
      start = ($urandom_range(0, 3) == 0);
      en    = ($urandom_range(0, 9) != 0);
      stall = ($urandom_range(0, 4) == 0);
      step  = 1'($urandom_range(0, 1));
      r     = $urandom_range(0, 9);
      sel   = (r == 0) ? 2'd1 : (r == 1) ? 2'd2 : (r == 2) ? 2'd3 : 2'd0;
      r     = $urandom_range(0, 7);
      br    = (r == 0) ? $urandom : (r == 1) ? 32'hFFFF_FFFF : $urandom_range(0, 300);
      jmp   = (r == 2) ? $urandom : $urandom_range(0, 300);
      wr_en = ($urandom_range(0, 3) == 0);
      wr_addr = 8'($urandom);
      wr_data = ($urandom_range(0, 15) == 0) ? HALT : $urandom;
      model_step(); tick();
      chk($sformatf("rnd%0d", k), pc, m_pc, instr, m_instr, inc, m_inc, valid, m_v, halt, m_h,
          st, 2'(m_st));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
